rf_wb_arbiter: RTL and testbench

- Shares the single write port (a3/di3/we3) of the GPR register file between two writeback requesters: 0 = execute/ALU, 1 = load/store unit.
- Round-robin arbitration with valid/ready handshakes.
- Registers the winning write into the register file.
- Flags read-after-write collisions on the two synchronous read ports, so decode can substitute fresh data for the stale value the register file returns.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 113 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// +--------------------------------------------------------------------+
// | rf_pkg: shared widths, requester indices and writeback request type |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package rf_pkg;

  localparam int XLEN    = 32;
  localparam int REG_CNT = 32;
  localparam int ADDR_W  = $clog2(REG_CNT);

  localparam int REQ_EXE = 0;
  localparam int REQ_LSU = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +--------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter, one-hot grant             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // The pointer only moves on contention, so a lone requester never steals priority.
  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (rst_n) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          grant    = rr_ptr_q ? 2'b10 : 2'b01;
          rr_ptr_d = ~rr_ptr_q;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter: shares the GPR write port, flags read-after-write    |
// | collisions for decode. Rev 1.0                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter #(
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int REG_CNT = rf_pkg::REG_CNT,
  parameter int ADDR_W  = $clog2(REG_CNT),
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [XLEN-1:0]   req_data0,
  input  logic [XLEN-1:0]   req_data1,
  output logic [1:0]        req_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [XLEN-1:0]   byp_data1,
  output logic [XLEN-1:0]   byp_data2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  import rf_pkg::*;

  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  logic              wb_we_q,    wb_we_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [XLEN-1:0]   wb_data_q,  wb_data_d;
  logic              byp_hit1_q, byp_hit1_d;
  logic              byp_hit2_q, byp_hit2_d;
  logic [XLEN-1:0]   byp_data1_q, byp_data1_d;
  logic [XLEN-1:0]   byp_data2_q, byp_data2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign sel_addr  = grant[REQ_LSU] ? req_addr1 : req_addr0;
  assign sel_data  = grant[REQ_LSU] ? req_data1 : req_data0;

  always_comb begin
    wb_we_d     = xfer && (sel_addr != '0);
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    if (wb_we_d) begin
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
    end
    // A read issued alongside an active write sees the old value one cycle later.
    byp_hit1_d  = wb_we_q && (wb_addr_q == rd_addr1) && (rd_addr1 != '0);
    byp_hit2_d  = wb_we_q && (wb_addr_q == rd_addr2) && (rd_addr2 != '0);
    byp_data1_d = wb_data_q;
    byp_data2_d = wb_data_q;
    cnt_d       = cnt_q;
    if ((req_valid == 2'b11) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      byp_hit1_q  <= 1'b0;
      byp_hit2_q  <= 1'b0;
      byp_data1_q <= '0;
      byp_data2_q <= '0;
      cnt_q       <= '0;
    end else begin
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      byp_hit1_q  <= byp_hit1_d;
      byp_hit2_q  <= byp_hit2_d;
      byp_data1_q <= byp_data1_d;
      byp_data2_q <= byp_data2_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_we        = wb_we_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign byp_hit1     = byp_hit1_q;
  assign byp_hit2     = byp_hit2_q;
  assign byp_data1    = byp_data1_q;
  assign byp_data2    = byp_data2_q;
  assign conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rf_wb_arbiter: directed + random bench against a behavioural    |
// | model of the arbiter, write stage and register file. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int XW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr0, req_addr1, rd_addr1, rd_addr2;
  logic [XW-1:0] req_data0, req_data1;

  logic [1:0]    req_ready;
  logic          wb_we, byp_hit1, byp_hit2;
  logic [AW-1:0] wb_addr;
  logic [XW-1:0] wb_data, byp_data1, byp_data2;
  logic [15:0]   conflict_cnt;

  logic [1:0]    s_req_ready;
  logic          s_wb_we, s_byp_hit1, s_byp_hit2;
  logic [AW-1:0] s_wb_addr;
  logic [XW-1:0] s_wb_data, s_byp_data1, s_byp_data2;
  logic [1:0]    s_conflict_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .conflict_cnt(conflict_cnt)
  );

  rf_wb_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(s_req_ready), .wb_we(s_wb_we), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(s_byp_hit1), .byp_hit2(s_byp_hit2),
    .byp_data1(s_byp_data1), .byp_data2(s_byp_data2),
    .conflict_cnt(s_conflict_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Requesters: each holds one pending write until it is accepted.
  bit            pend  [2];
  logic [AW-1:0] paddr [2];
  logic [XW-1:0] pdata [2];

  // Behavioural model state.
  bit            m_pref;        // requester that wins the next contended cycle
  bit            m_we;
  logic [AW-1:0] m_waddr;
  logic [XW-1:0] m_wdata;
  bit            m_hit1, m_hit2;
  logic [XW-1:0] m_bd1, m_bd2;
  int            m_cnt, m_cnt2;
  logic [XW-1:0] regs [32];
  logic [1:0]    last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refill(input int i, input bit allow_zero);
    pend[i]  = 1'b1;
    paddr[i] = allow_zero ? AW'($urandom_range(0, 7)) : AW'($urandom_range(1, 31));
    pdata[i] = $urandom;
  endtask

  task automatic tick(input bit rstv);
    logic [1:0]    g;
    int            w;
    logic [XW-1:0] stale1, stale2, arch1, arch2, eff1, eff2;
    rst_n     = rstv;
    req_valid = {pend[1], pend[0]};
    req_addr0 = paddr[0]; req_data0 = pdata[0];
    req_addr1 = paddr[1]; req_data1 = pdata[1];
    #1;
    g = 2'b00;
    if (rstv) begin
      if (pend[0] && pend[1]) g = m_pref ? 2'b10 : 2'b01;
      else if (pend[0])       g = 2'b01;
      else if (pend[1])       g = 2'b10;
    end
    last_ready = req_ready;
    chk("req_ready", {62'd0, req_ready}, {62'd0, g});
    chk("req_ready_sat", {62'd0, s_req_ready}, {62'd0, g});

    // Register file: reads sample before this cycle's write commits.
    stale1 = regs[rd_addr1];
    stale2 = regs[rd_addr2];
    if (m_we) regs[m_waddr] = m_wdata;
    arch1 = regs[rd_addr1];
    arch2 = regs[rd_addr2];

    if (!rstv) begin
      m_pref = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_hit1 = 1'b0; m_hit2 = 1'b0; m_bd1 = '0; m_bd2 = '0;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_hit1 = m_we && (m_waddr == rd_addr1) && (rd_addr1 != 0);
      m_hit2 = m_we && (m_waddr == rd_addr2) && (rd_addr2 != 0);
      m_bd1  = m_wdata;
      m_bd2  = m_wdata;
      if (pend[0] && pend[1]) begin
        m_pref = ~m_pref;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_we = 1'b0;
      if (g != 2'b00) begin
        w = g[1] ? 1 : 0;
        pend[w] = 1'b0;
        if (paddr[w] != 0) begin
          m_we = 1'b1; m_waddr = paddr[w]; m_wdata = pdata[w];
        end
      end
    end

    @(posedge clk); #1;
    chk("wb_we", {63'd0, wb_we}, {63'd0, m_we});
    chk("wb_addr", {59'd0, wb_addr}, {59'd0, m_waddr});
    chk("wb_data", {32'd0, wb_data}, {32'd0, m_wdata});
    chk("byp_hit1", {63'd0, byp_hit1}, {63'd0, m_hit1});
    chk("byp_hit2", {63'd0, byp_hit2}, {63'd0, m_hit2});
    chk("byp_data1", {32'd0, byp_data1}, {32'd0, m_bd1});
    chk("byp_data2", {32'd0, byp_data2}, {32'd0, m_bd2});
    chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cnt));
    chk("conflict_cnt_sat", {62'd0, s_conflict_cnt}, 64'(m_cnt2));
    if (rstv) begin
      // Decode's corrected view must equal the architectural value after the commit.
      eff1 = byp_hit1 ? byp_data1 : stale1;
      eff2 = byp_hit2 ? byp_data2 : stale2;
      chk("read1_value", {32'd0, eff1}, {32'd0, arch1});
      chk("read2_value", {32'd0, eff2}, {32'd0, arch2});
    end
  endtask

  initial begin
    logic [1:0] grants [4];
    for (int i = 0; i < 32; i++) regs[i] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = '0; paddr[1] = '0; pdata[0] = '0; pdata[1] = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    m_pref = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    m_hit1 = 1'b0; m_hit2 = 1'b0; m_bd1 = '0; m_bd2 = '0; m_cnt = 0; m_cnt2 = 0;
    rst_n = 1'b0; req_valid = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
    @(posedge clk); #1;

    // Reset with both requesting, then first grant to requester 0.
    pend[0] = 1'b1; paddr[0] = 5'd1; pdata[0] = 32'h11;
    pend[1] = 1'b1; paddr[1] = 5'd2; pdata[1] = 32'h22;
    tick(1'b0);
    tick(1'b0);
    chk("reset_wb_we", {63'd0, wb_we}, 64'd0);
    chk("reset_cnt", {48'd0, conflict_cnt}, 64'd0);
    tick(1'b1);
    chk("first_grant", {62'd0, last_ready}, 64'd1);
    tick(1'b1);

    // Single requester.
    pend[0] = 1'b1; paddr[0] = 5'd5; pdata[0] = 32'hDEADBEEF;
    tick(1'b1);
    chk("single_ready", {62'd0, last_ready}, 64'd1);
    chk("single_we", {63'd0, wb_we}, 64'd1);
    chk("single_addr", {59'd0, wb_addr}, 64'd5);
    chk("single_data", {32'd0, wb_data}, 64'hDEADBEEF);

    // Contention: four cycles, new data after each acceptance.
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    for (int c = 0; c < 4; c++) begin
      if (!pend[0]) refill(0, 1'b0);
      if (!pend[1]) refill(1, 1'b0);
      tick(1'b1);
      grants[c] = last_ready;
    end
    chk("cont_grant0", {62'd0, grants[0]}, 64'd1);
    chk("cont_grant1", {62'd0, grants[1]}, 64'd2);
    chk("cont_grant2", {62'd0, grants[2]}, 64'd1);
    chk("cont_grant3", {62'd0, grants[3]}, 64'd2);
    chk("cont_cnt4", {48'd0, conflict_cnt}, 64'd4);

    // Saturation on the narrow counter.
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    for (int c = 0; c < 6; c++) begin
      if (!pend[0]) refill(0, 1'b0);
      if (!pend[1]) refill(1, 1'b0);
      tick(1'b1);
    end
    chk("sat_cnt", {62'd0, s_conflict_cnt}, 64'd3);
    chk("wide_cnt6", {48'd0, conflict_cnt}, 64'd6);

    // x0 write is accepted but never reaches the register file.
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    pend[1] = 1'b1; paddr[1] = 5'd0; pdata[1] = 32'h1234;
    tick(1'b1);
    chk("x0_ready", {62'd0, last_ready}, 64'd2);
    chk("x0_we", {63'd0, wb_we}, 64'd0);

    // Bypass hits.
    pend[0] = 1'b1; paddr[0] = 5'd7; pdata[0] = 32'hA5A5A5A5;
    tick(1'b1);
    rd_addr1 = 5'd7; rd_addr2 = 5'd3;
    tick(1'b1);
    chk("byp_hit1_dir", {63'd0, byp_hit1}, 64'd1);
    chk("byp_data1_dir", {32'd0, byp_data1}, 64'hA5A5A5A5);
    chk("byp_hit2_dir", {63'd0, byp_hit2}, 64'd0);
    pend[0] = 1'b1; paddr[0] = 5'd7; pdata[0] = 32'h5A5A5A5A;
    tick(1'b1);
    rd_addr1 = 5'd0; rd_addr2 = 5'd7;
    tick(1'b1);
    chk("byp_hit1_x0", {63'd0, byp_hit1}, 64'd0);
    chk("byp_hit2_dir", {63'd0, byp_hit2}, 64'd1);

    // Reset while a write is staged.
    pend[0] = 1'b1; paddr[0] = 5'd9; pdata[0] = 32'hCAFEF00D;
    tick(1'b1);
    tick(1'b0);
    chk("midreset_we", {63'd0, wb_we}, 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) != 0)) refill(i, 1'b1);
      end
      rd_addr1 = AW'($urandom_range(0, 7));
      rd_addr2 = AW'($urandom_range(0, 7));
      tick(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
